// File: rtl/if_pkg.sv
// Shared constants and the queue entry type for the instruction fetch stage.
package if_pkg;

    localparam logic [31:0] NOP          = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int          PC_INC       = 4;
    localparam int          QDEPTH       = 2;
    localparam int          DEF_DW       = 32;
    localparam int          DEF_IW       = 32;

    typedef struct packed {
        logic [DEF_DW-1:0] pc;
        logic [DEF_IW-1:0] instr;
    } if_entry_t;

endpackage

// File: rtl/if_queue.sv
// Two-entry synchronous FIFO holding fetched {pc, instr} words for decode.
module if_queue
    import if_pkg::*;
#(
    parameter int EW = DEF_DW + DEF_IW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [EW-1:0] wdata,
    output logic [1:0]    count,
    output logic [EW-1:0] head
);

    logic [EW-1:0] mem [QDEPTH];
    logic          hd;
    logic          tl;

    assign head = mem[hd];

    // Flush drops the whole queue; any same-cycle pop was already presented to decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            hd     <= 1'b0;
            tl     <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            count <= 2'd0;
            hd    <= 1'b0;
            tl    <= 1'b0;
        end else begin
            if (push) begin
                mem[tl] <= wdata;
                tl      <= ~tl;
            end
            if (pop) begin
                hd <= ~hd;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: pc register driving a combinational IM, feeding decode through a 2-entry queue.
module fetch_unit
    import if_pkg::*;
#(
    parameter int              IMW      = 4,
    parameter int              IW       = 32,
    parameter int              DW       = 32,
    parameter logic [DW-1:0]   RESET_PC = DEF_RESET_PC
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    output logic [IMW-1:0] im_addr,
    input  logic [IW-1:0]  im_data,
    input  logic           redir_valid,
    input  logic [DW-1:0]  redir_pc,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [IW-1:0]  out_instr,
    output logic [DW-1:0]  out_pc
);

    logic [DW-1:0]    pc;
    logic [1:0]       count;
    logic             pop;
    logic             push;
    logic [DW+IW-1:0] head;
    logic             unused_redir_lo;

    assign im_addr   = pc[IMW+1:2];
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid & out_ready;
    // A full queue can still accept when its head leaves in the same cycle.
    assign push      = run & ~redir_valid & ((count < 2'(QDEPTH)) | pop);

    assign unused_redir_lo = ^redir_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redir_valid) begin
            pc <= {redir_pc[DW-1:2], 2'b00};
        end else if (push) begin
            pc <= pc + DW'(PC_INC);
        end
    end

    if_queue #(
        .EW(DW + IW)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redir_valid),
        .wdata ({pc, im_data}),
        .count (count),
        .head  (head)
    );

    assign {out_pc, out_instr} = head;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a queue-based reference of the fetch stream.
module tb_fetch_unit;
    import if_pkg::*;

    localparam int IMW = 4;
    localparam int IW  = 32;
    localparam int DW  = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           run;
    logic [IMW-1:0] im_addr;
    logic [IW-1:0]  im_data;
    logic           redir_valid;
    logic [DW-1:0]  redir_pc;
    logic           out_valid;
    logic           out_ready;
    logic [IW-1:0]  out_instr;
    logic [DW-1:0]  out_pc;

    int vectors     = 0;
    int miscompares = 0;

    if_entry_t     exp_q[$];
    if_entry_t     got_q[$];
    if_entry_t     exp_h;
    logic [DW-1:0] mpc;

    always #5 clk = ~clk;

    assign im_data = 32'hA000_0000 | {28'd0, im_addr};

    fetch_unit #(
        .IMW(IMW), .IW(IW), .DW(DW), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .im_addr(im_addr), .im_data(im_data),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic if_entry_t exp_head();
        if (exp_q.size() != 0) return exp_q[0];
        return '0;
    endfunction

    // Reference: the queue is a list of fetched words; fetching follows the pc in program order.
    task automatic model_clock();
        bit        pop_m;
        bit        room;
        if_entry_t e;
        pop_m = (exp_q.size() != 0) && out_ready;
        if (redir_valid) begin
            exp_q.delete();
            mpc = {redir_pc[DW-1:2], 2'b00};
        end else begin
            room = (exp_q.size() < 2) || pop_m;
            if (pop_m) void'(exp_q.pop_front());
            if (run && room) begin
                e.pc    = mpc;
                e.instr = 32'hA000_0000 | {28'd0, mpc[IMW+1:2]};
                exp_q.push_back(e);
                mpc = mpc + 32'd4;
            end
        end
    endtask

    task automatic drive(input logic r, input logic rdy, input logic rv, input logic [DW-1:0] rpc);
        run         = r;
        out_ready   = rdy;
        redir_valid = rv;
        redir_pc    = rpc;
        #1;
    endtask

    task automatic cycle();
        if_entry_t g;
        if (out_valid && out_ready) begin
            g.pc    = out_pc;
            g.instr = out_instr;
            got_q.push_back(g);
        end
        model_clock();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        got_q.delete();
        mpc = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; out_ready = 1'b0; redir_valid = 1'b0; redir_pc = '0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        vectors++;
        if (out_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 0", out_pc); end
        vectors++;
        if (out_instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h want 0", out_instr); end
        vectors++;
        if (im_addr !== 4'd0) begin miscompares++; $display("FAIL reset_im_addr: got %h want 0", im_addr); end
        do_reset();
    endtask

    task automatic test_stream();
        logic v0, v1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, '0);
            if (i == 0) v0 = out_valid;
            if (i == 1) v1 = out_valid;
            exp_h = exp_head();
            vectors++;
            if (out_valid !== (exp_q.size() != 0) || im_addr !== mpc[IMW+1:2] ||
                (out_valid && {out_pc, out_instr} !== exp_h)) begin
                miscompares++;
                $display("FAIL stream[%0d]: got v=%b pc=%h instr=%h addr=%h want v=%0d pc=%h instr=%h addr=%h",
                         i, out_valid, out_pc, out_instr, im_addr, exp_q.size() != 0, exp_h.pc, exp_h.instr, mpc[IMW+1:2]);
            end
            cycle();
        end
        vectors++;
        if (v0 !== 1'b0 || v1 !== 1'b1) begin
            miscompares++; $display("FAIL stream_latency: got valid %b,%b want 0,1", v0, v1);
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (got_q.size() <= k) begin
                miscompares++; $display("FAIL stream_entry[%0d]: got nothing want pc=%h", k, 4 * k);
            end else if (got_q[k].pc !== 32'(4 * k) || got_q[k].instr !== (32'hA000_0000 | 32'(k))) begin
                miscompares++;
                $display("FAIL stream_entry[%0d]: got pc=%h instr=%h want pc=%h instr=%h",
                         k, got_q[k].pc, got_q[k].instr, 4 * k, 32'hA000_0000 | 32'(k));
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 1'b1, 1'b0, '0);
            cycle();
        end
        vectors++;
        if (got_q.size() < 17) begin
            miscompares++; $display("FAIL wrap_count: got %0d entries want 17", got_q.size());
        end else begin
            if (got_q[15] !== {32'h3C, 32'hA000_000F}) begin
                miscompares++; $display("FAIL wrap_16th: got pc=%h instr=%h want pc=3c instr=a000000f", got_q[15].pc, got_q[15].instr);
            end
            vectors++;
            if (got_q[16] !== {32'h40, 32'hA000_0000}) begin
                miscompares++; $display("FAIL wrap_17th: got pc=%h instr=%h want pc=40 instr=a0000000", got_q[16].pc, got_q[16].instr);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, (i >= 6), 1'b0, '0);
            exp_h = exp_head();
            vectors++;
            if (out_valid !== (exp_q.size() != 0) || im_addr !== mpc[IMW+1:2] ||
                (out_valid && {out_pc, out_instr} !== exp_h)) begin
                miscompares++;
                $display("FAIL backpressure[%0d]: got v=%b pc=%h instr=%h addr=%h want v=%0d pc=%h instr=%h addr=%h",
                         i, out_valid, out_pc, out_instr, im_addr, exp_q.size() != 0, exp_h.pc, exp_h.instr, mpc[IMW+1:2]);
            end
            if (i == 5) begin
                vectors++;
                if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'hA000_0000 || im_addr !== 4'd2) begin
                    miscompares++;
                    $display("FAIL backpressure_hold: got v=%b pc=%h instr=%h addr=%h want v=1 pc=0 instr=a0000000 addr=2",
                             out_valid, out_pc, out_instr, im_addr);
                end
            end
            cycle();
        end
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (got_q.size() <= k || got_q[k].pc !== 32'(4 * k)) begin
                miscompares++;
                $display("FAIL backpressure_order[%0d]: got pc=%h want pc=%h", k,
                         (got_q.size() > k) ? got_q[k].pc : 32'hFFFF_FFFF, 4 * k);
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 1'b0, '0); cycle(); end
        drive(1'b1, 1'b0, 1'b1, 32'h26);
        cycle();
        drive(1'b1, 1'b0, 1'b0, '0);
        vectors++;
        if (out_valid !== 1'b0 || im_addr !== 4'd9) begin
            miscompares++; $display("FAIL redirect_flush: got v=%b addr=%h want v=0 addr=9", out_valid, im_addr);
        end
        cycle();
        drive(1'b1, 1'b1, 1'b0, '0);
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 32'h24 || out_instr !== 32'hA000_0009) begin
            miscompares++;
            $display("FAIL redirect_target: got v=%b pc=%h instr=%h want v=1 pc=24 instr=a0000009", out_valid, out_pc, out_instr);
        end
        cycle();
    endtask

    task automatic test_redirect_pop();
        do_reset();
        for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 1'b0, '0); cycle(); end
        drive(1'b1, 1'b1, 1'b1, 32'h10);
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
            miscompares++; $display("FAIL redirpop_deliver: got v=%b pc=%h want v=1 pc=0", out_valid, out_pc);
        end
        cycle();
        drive(1'b1, 1'b1, 1'b0, '0);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL redirpop_empty: got v=%b want 0", out_valid);
        end
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, '0);
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== 32'(32'h10 + 4 * i) || out_instr !== (32'hA000_0004 + 32'(i))) begin
                miscompares++;
                $display("FAIL redirpop_stream[%0d]: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                         i, out_valid, out_pc, out_instr, 32'h10 + 4 * i, 32'hA000_0004 + 32'(i));
            end
            cycle();
        end
    endtask

    task automatic test_run_pause();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(!(i >= 4 && i < 8), 1'b1, 1'b0, '0);
            exp_h = exp_head();
            vectors++;
            if (out_valid !== (exp_q.size() != 0) || im_addr !== mpc[IMW+1:2] ||
                (out_valid && {out_pc, out_instr} !== exp_h)) begin
                miscompares++;
                $display("FAIL pause[%0d]: got v=%b pc=%h instr=%h addr=%h want v=%0d pc=%h instr=%h addr=%h",
                         i, out_valid, out_pc, out_instr, im_addr, exp_q.size() != 0, exp_h.pc, exp_h.instr, mpc[IMW+1:2]);
            end
            if (i == 7) begin
                vectors++;
                if (out_valid !== 1'b0 || im_addr !== 4'd4) begin
                    miscompares++; $display("FAIL pause_hold: got v=%b addr=%h want v=0 addr=4", out_valid, im_addr);
                end
            end
            if (i == 9) begin
                vectors++;
                if (out_valid !== 1'b1 || out_pc !== 32'h10) begin
                    miscompares++; $display("FAIL pause_resume: got v=%b pc=%h want v=1 pc=10", out_valid, out_pc);
                end
            end
            cycle();
        end
    endtask

    task automatic test_midreset();
        do_reset();
        for (int i = 0; i < 5; i++) begin drive(1'b1, 1'b1, 1'b0, '0); cycle(); end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || im_addr !== 4'd0) begin
            miscompares++;
            $display("FAIL midreset_async: got v=%b pc=%h instr=%h addr=%h want all 0", out_valid, out_pc, out_instr, im_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        got_q.delete();
        mpc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, '0);
            if (i == 1) begin
                vectors++;
                if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'hA000_0000) begin
                    miscompares++;
                    $display("FAIL midreset_first: got v=%b pc=%h instr=%h want v=1 pc=0 instr=a0000000", out_valid, out_pc, out_instr);
                end
            end
            cycle();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, $urandom);
            exp_h = exp_head();
            vectors++;
            if (out_valid !== (exp_q.size() != 0) || im_addr !== mpc[IMW+1:2] ||
                (out_valid && {out_pc, out_instr} !== exp_h)) begin
                miscompares++;
                $display("FAIL random[%0d]: got v=%b pc=%h instr=%h addr=%h want v=%0d pc=%h instr=%h addr=%h",
                         i, out_valid, out_pc, out_instr, im_addr, exp_q.size() != 0, exp_h.pc, exp_h.instr, mpc[IMW+1:2]);
            end
            cycle();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_wrap();
        test_backpressure();
        test_redirect();
        test_redirect_pop();
        test_run_pause();
        test_midreset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
